// File: rtl/fetch_unit.sv
// Y86-64 fetch stage: fetches one instruction a byte at a time over a req/ack
// memory port, decodes its fields and hands it to execute via valid/ready.
module fetch_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] pc_in,
    input  logic        pc_load,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [7:0]  imem_data,
    input  logic        imem_err,
    output logic [63:0] pc_out,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [1:0]  stat,
    output logic        instr_valid,
    input  logic        instr_ready
);
    localparam logic [1:0] AOK = 2'd0, HLT = 2'd1, ADR = 2'd2, INS = 2'd3;

    typedef enum logic [1:0] {FETCH, VALID, IDLE, HALTED} state_t;

    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } dec_t;

    localparam dec_t DEC_CLR = '{stat: AOK, icode: 4'h0, ifun: 4'h0, ra: 4'hF,
                                 rb: 4'hF, valc: 64'd0, valp: 64'd0};

    state_t      state;
    logic [63:0] pc;
    logic [3:0]  idx;
    dec_t        dec;

    function automatic logic [3:0] ilen(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: ilen = 4'd2;
            4'h7, 4'h8:             ilen = 4'd9;
            4'h3, 4'h4, 4'h5:       ilen = 4'd10;
            default:                ilen = 4'd1;  // 0, 1, 9 and invalid codes
        endcase
    endfunction

    logic [3:0]  cur_icode;
    logic        last_byte;
    logic [63:0] next_valp;
    logic        has_regs;
    logic        has_c8;
    logic        has_c10;
    logic [2:0]  slot;

    // On byte 0 the length comes straight from the incoming byte; afterwards
    // from the registered icode.
    always_comb begin
        cur_icode = (idx == 4'd0) ? imem_data[7:4] : dec.icode;
        last_byte = (idx == ilen(cur_icode) - 4'd1);
        next_valp = pc + {60'd0, idx} + 64'd1;
        has_regs  = dec.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
        has_c8    = dec.icode inside {4'h7, 4'h8};
        has_c10   = dec.icode inside {4'h3, 4'h4, 4'h5};
        slot      = idx[2:0] - (has_c8 ? 3'd1 : 3'd2);
    end

    assign imem_addr = pc + {60'd0, idx};
    assign pc_out    = pc;
    assign icode     = dec.icode;
    assign ifun      = dec.ifun;
    assign rA        = dec.ra;
    assign rB        = dec.rb;
    assign valC      = dec.valc;
    assign valP      = dec.valp;
    assign stat      = dec.stat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= 64'd0;
            idx         <= 4'd0;
            dec         <= DEC_CLR;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    // req is held low through reset, so the first cycle after
                    // release only raises it.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        if (imem_err) begin
                            dec.stat    <= ADR;
                            dec.valp    <= next_valp;
                            imem_req    <= 1'b0;
                            instr_valid <= 1'b1;
                            state       <= VALID;
                        end else begin
                            idx <= idx + 4'd1;
                            if (idx == 4'd0) begin
                                dec.icode <= imem_data[7:4];
                                dec.ifun  <= imem_data[3:0];
                                if (imem_data[7:4] == 4'h0)
                                    dec.stat <= HLT;
                                else if (imem_data[7:4] > 4'hB)
                                    dec.stat <= INS;
                            end else if (idx == 4'd1 && has_regs) begin
                                dec.ra <= imem_data[7:4];
                                dec.rb <= imem_data[3:0];
                            end else if (has_c8 || (has_c10 && idx >= 4'd2)) begin
                                dec.valc[{slot, 3'b000} +: 8] <= imem_data;
                            end
                            if (last_byte) begin
                                dec.valp    <= next_valp;
                                imem_req    <= 1'b0;
                                instr_valid <= 1'b1;
                                state       <= VALID;
                            end
                        end
                    end
                end
                VALID: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= (dec.stat != AOK) ? HALTED : IDLE;
                    end
                end
                IDLE: begin
                    if (pc_load) begin
                        pc       <= pc_in;
                        idx      <= 4'd0;
                        dec      <= DEC_CLR;
                        imem_req <= 1'b1;
                        state    <= FETCH;
                    end
                end
                default: ;  // HALTED: only reset leaves
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: byte memory responder with stalls/errors, table vectors,
// randomized instructions against an ISA-level model, and reset/halt sequences.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] pc_in = 64'd0;
    logic        pc_load = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [7:0]  imem_data = 8'd0;
    logic        imem_err = 1'b0;
    logic [63:0] pc_out;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic [1:0]  stat;
    logic        instr_valid;
    logic        instr_ready = 1'b0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_load(pc_load),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_data(imem_data), .imem_err(imem_err), .pc_out(pc_out),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
        .stat(stat), .instr_valid(instr_valid), .instr_ready(instr_ready)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  prog [10];
    int          stall [10];
    logic [63:0] base = 64'd0;
    int          err_at = -1;
    logic [63:0] addr_q [$];
    int          cur_off = -1;
    int          waited = 0;
    int          len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: serves prog[] at base.., holding ack low stall[k] cycles per byte.
    always @(negedge clk) begin : resp
        logic [63:0] d;
        int off;
        if (!imem_req) begin
            imem_ack = 1'b0;
            imem_err = 1'b0;
            cur_off  = -1;
        end else begin
            d   = imem_addr - base;
            off = (d < 64'd10) ? int'(d) : -1;
            if (off != cur_off) begin
                cur_off = off;
                waited  = 0;
            end
            if (off < 0) begin
                imem_ack = 1'b0;
            end else if (waited < stall[off]) begin
                imem_ack = 1'b0;
                waited++;
            end else begin
                imem_ack  = 1'b1;
                imem_data = prog[off];
                imem_err  = (off == err_at);
                addr_q.push_back(imem_addr);
            end
        end
    end

    task automatic set_prog(input logic [63:0] pc, input logic [79:0] b, input int err);
        base   = pc;
        err_at = err;
        for (int k = 0; k < 10; k++) begin
            prog[k]  = b[8*k +: 8];
            stall[k] = 0;
        end
        addr_q.delete();
    endtask

    task automatic do_load(input logic [63:0] pc);
        @(negedge clk);
        pc_in   = pc;
        pc_load = 1'b1;
        @(posedge clk);
        #1 pc_load = 1'b0;
        chk("load_req", 64'(imem_req), 64'd1);
        chk("load_addr", imem_addr, pc);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!instr_valid && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
        end
        if (!instr_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL valid_timeout: instr_valid still 0 after %0d cycles", cyc);
        end
    endtask

    task automatic accept();
        @(negedge clk);
        instr_ready = 1'b1;
        @(posedge clk);
        #1 instr_ready = 1'b0;
        chk("accept_drop", {62'd0, instr_valid, imem_req}, 64'd0);
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_ctl"}, {60'd0, instr_valid, imem_req, stat}, 64'd0);
        chk({nm, "_fields"}, {48'd0, icode, ifun, rA, rB}, 64'h00FF);
        chk({nm, "_valc"}, valC, 64'd0);
        chk({nm, "_valp"}, valP, 64'd0);
        chk({nm, "_pc"}, pc_out | imem_addr, 64'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_req", 64'(imem_req), 64'd1);
        chk("rel_addr", imem_addr, 64'd0);
    endtask

    // ISA-level expectation for the instruction at base/prog[].
    task automatic model_check(input string nm, input int cyc);
        int ic, len, fetched, ecyc, bad;
        logic [1:0]  est;
        logic [3:0]  era, erb;
        logic [63:0] evc;
        ic      = int'(prog[0][7:4]);
        len     = len_tab[ic];
        fetched = (err_at >= 0 && err_at < len) ? err_at + 1 : len;
        est     = (err_at >= 0 && err_at < len) ? 2'd2 : (ic == 0) ? 2'd1 : (ic > 11) ? 2'd3 : 2'd0;
        ecyc    = fetched;
        for (int k = 0; k < fetched; k++) ecyc += stall[k];
        era = 4'hF;
        erb = 4'hF;
        if (len == 2 || len == 10) {era, erb} = prog[1];
        evc = 64'd0;
        if (len >= 9)
            for (int k = 0; k < 8; k++) evc |= 64'(prog[len - 8 + k]) << (8 * k);
        bad = (addr_q.size() != fetched) ? 1 : 0;
        if (bad == 0)
            for (int k = 0; k < fetched; k++) if (addr_q[k] != base + 64'(k)) bad++;
        chk({nm, "_addrs"}, 64'(bad), 64'd0);
        chk({nm, "_cycles"}, 64'(cyc), 64'(ecyc));
        chk({nm, "_stat"}, 64'(stat), 64'(est));
        chk({nm, "_valp"}, valP, base + 64'(fetched));
        chk({nm, "_pc"}, pc_out, base);
        if (est != 2'd2) begin
            chk({nm, "_op"}, {56'd0, icode, ifun}, {56'd0, prog[0]});
            chk({nm, "_regs"}, {56'd0, rA, rB}, {56'd0, era, erb});
            chk({nm, "_valc"}, valC, evc);
        end
    endtask

    task automatic check_halted(input string nm, input logic [1:0] est);
        int reqs;
        @(negedge clk);
        pc_in   = 64'h500;
        pc_load = 1'b1;
        @(posedge clk);
        #1 pc_load = 1'b0;
        reqs = int'(imem_req);
        repeat (5) begin
            @(posedge clk);
            #1 reqs += int'(imem_req) + int'(instr_valid);
        end
        chk({nm, "_noreq"}, 64'(reqs), 64'd0);
        chk({nm, "_held"}, 64'(stat), 64'(est));
    endtask

    typedef struct {
        logic [63:0] pc;
        logic [79:0] b;
        logic [3:0]  ic, fn, ra, rb;
        logic [63:0] vc, vp;
        int          len;
    } vec_t;

    vec_t        tab [9];
    int          cyc;
    int          guard;
    int          reqs;
    logic [79:0] rb;
    logic [63:0] rpc;

    initial begin
        tab[0] = '{64'h200, 80'h10, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h201, 1};
        tab[1] = '{64'h100, 80'h1122334455667788F330, 4'h3, 4'h0, 4'hF, 4'h3,
                   64'h1122334455667788, 64'h10A, 10};
        tab[2] = '{64'h1000, 80'h0000000000DEADBEEF80, 4'h8, 4'h0, 4'hF, 4'hF,
                   64'hDEADBEEF, 64'h1009, 9};
        tab[3] = '{64'h2000, 80'h2361, 4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'h2002, 2};
        tab[4] = '{64'h3001, 80'h90, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h3002, 1};
        tab[5] = '{64'h40, 80'h01020304050607081540, 4'h4, 4'h0, 4'h1, 4'h5,
                   64'h0102030405060708, 64'h4A, 10};
        tab[6] = '{64'h50, 80'h6725, 4'h2, 4'h5, 4'h6, 4'h7, 64'h0, 64'h52, 2};
        tab[7] = '{64'h60, 80'h4FA0, 4'hA, 4'h0, 4'h4, 4'hF, 64'h0, 64'h62, 2};
        tab[8] = '{64'hFFFF_FFFF_FFFF_FFFA, 80'h8000000000000001AB50, 4'h5, 4'h0,
                   4'hA, 4'hB, 64'h8000000000000001, 64'h4, 10};

        // Reset, then jXX at address 0 straight out of reset
        set_prog(64'h0, 80'h00000000000000020073, -1);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset("reset");
        release_reset();
        wait_valid(cyc);
        model_check("jxx", cyc);
        chk("jxx_valc", valC, 64'h200);
        chk("jxx_valp", valP, 64'h9);
        chk("jxx_op", {56'd0, icode, ifun}, 64'h73);
        accept();

        foreach (tab[i]) begin
            set_prog(tab[i].pc, tab[i].b, -1);
            do_load(tab[i].pc);
            wait_valid(cyc);
            chk($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(tab[i].len));
            chk($sformatf("vec%0d_op", i), {56'd0, icode, ifun}, {56'd0, tab[i].ic, tab[i].fn});
            chk($sformatf("vec%0d_regs", i), {56'd0, rA, rB}, {56'd0, tab[i].ra, tab[i].rb});
            chk($sformatf("vec%0d_valc", i), valC, tab[i].vc);
            chk($sformatf("vec%0d_valp", i), valP, tab[i].vp);
            chk($sformatf("vec%0d_stat", i), 64'(stat), 64'd0);
            chk($sformatf("vec%0d_pc", i), pc_out, tab[i].pc);
            accept();
        end

        for (int i = 0; i < 40; i++) begin
            rb[31:0]  = $urandom;
            rb[63:32] = $urandom;
            rb[79:64] = 16'($urandom);
            rb[7:4]   = 4'($urandom_range(1, 11));
            rpc = (i % 4 == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7))
                               : {$urandom, $urandom};
            set_prog(rpc, rb, -1);
            for (int k = 0; k < 10; k++) stall[k] = $urandom_range(0, 2);
            do_load(rpc);
            wait_valid(cyc);
            model_check($sformatf("rand%0d", i), cyc);
            accept();
        end

        // Wrap with a 3-cycle stall on byte 1
        set_prog(64'hFFFF_FFFF_FFFF_FFFF, 80'h1260, -1);
        stall[1] = 3;
        do_load(64'hFFFF_FFFF_FFFF_FFFF);
        wait_valid(cyc);
        model_check("wrap", cyc);
        chk("wrap_cyc", 64'(cyc), 64'd5);
        chk("wrap_valp", valP, 64'h1);
        chk("wrap_n", 64'(addr_q.size()), 64'd2);
        if (addr_q.size() == 2) chk("wrap_addr1", addr_q[1], 64'd0);
        accept();

        // Address error on byte 2 of rmmovq
        set_prog(64'h40, 80'h01020304050607081540, 2);
        do_load(64'h40);
        wait_valid(cyc);
        model_check("adrerr", cyc);
        chk("adrerr_stat", 64'(stat), 64'd2);
        chk("adrerr_valp", valP, 64'h43);
        reqs = 0;
        repeat (3) begin
            @(posedge clk);
            #1 reqs += int'(imem_req);
        end
        chk("adrerr_noreq", 64'(reqs), 64'd0);
        chk("adrerr_hold", 64'(instr_valid), 64'd1);
        accept();
        check_halted("adrerr_halt", 2'd2);

        // halt and invalid opcode, each from reset at address 0
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            rst_n = 1'b0;
            set_prog(64'h0, (t == 0) ? 80'h00 : 80'hD0, -1);
            @(posedge clk);
            #1 check_reset("hreset");
            release_reset();
            wait_valid(cyc);
            model_check((t == 0) ? "hlt" : "ins", cyc);
            chk("hi_stat", 64'(stat), (t == 0) ? 64'd1 : 64'd3);
            chk("hi_valp", valP, 64'h1);
            accept();
            check_halted((t == 0) ? "hlt_halt" : "ins_halt", (t == 0) ? 2'd1 : 2'd3);
        end

        // Reset while byte 4 of an irmovq is outstanding
        @(negedge clk);
        rst_n = 1'b0;
        set_prog(64'h0, 80'h1122334455667788F330, -1);
        @(posedge clk);
        #1;
        release_reset();
        guard = 0;
        while (addr_q.size() < 4 && guard < 50) begin
            @(posedge clk);
            #1 guard++;
        end
        chk("mid_reach", 64'(addr_q.size()), 64'd4);
        rst_n = 1'b0;
        #1 check_reset("mid_rst");
        set_prog(64'h0, 80'h1122334455667788F330, -1);
        release_reset();
        wait_valid(cyc);
        model_check("mid_restart", cyc);
        chk("mid_valc", valC, 64'h1122334455667788);
        accept();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Y86-64 instruction fetch stage with its own PC register. Reads instruction bytes one at a time from a byte-wide instruction memory through a req/ack handshake. Assembles icode/ifun/rA/rB/valC, computes valP, and presents the decoded instruction to execute with a valid/ready handshake. Consumes the next PC from the PC-update stage via `pc_load`/`pc_in` and sits directly upstream of decode.

## Interface
- No parameters. Widths are fixed by the Y86-64 ISA.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pc_in` in 64: next PC from PC update.
- `pc_load` in 1: strobe that loads `pc_in`; honoured only in IDLE.
- `imem_req` out 1: byte read request.
- `imem_addr` out 64: byte address, equal to pc + byte index, mod 2^64.
- `imem_ack` in 1: byte delivered this cycle.
- `imem_data` in 8: byte, valid when `imem_ack` is high.
- `imem_err` in 1: address error, qualified by `imem_ack`.
- `pc_out` out 64: PC of the presented instruction.
- `icode`, `ifun`, `rA`, `rB` out 4 each: decoded fields.
- `valC` out 64: little-endian constant.
- `valP` out 64: pc + length, mod 2^64.
- `stat` out 2: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- `instr_valid` out 1: outputs hold a complete instruction.
- `instr_ready` in 1: consumer accepts the instruction.

## Operation
- **States:** FETCH, VALID, IDLE, HALTED.
- **Reset state:**
  - pc = 0, state FETCH, byte index 0.
  - All outputs 0 except `stat`=AOK, `rA`=`rB`=0xF.
  - `imem_req` is 0 while `rst_n` is low.
- **FETCH:**
  - `imem_req`=1 continuously; `imem_addr` = pc + idx.
  - On `imem_ack`, store the byte and increment idx. `imem_addr` advances the following cycle.
  - Byte 0: icode = [7:4], ifun = [3:0]. This byte determines the instruction length.
- **Instruction lengths:**
  - 1 byte: icode 0, 1, 9.
  - 2 bytes: icode 2, 6, 10, 11.
  - 9 bytes: icode 7, 8.
  - 10 bytes: icode 3, 4, 5.
  - icode > 11: `stat`=INS, length 1, go to VALID immediately.
- **Field extraction:**
  - Byte 1 of 2- and 10-byte instructions: rA = [7:4], rB = [3:0].
  - valC: bytes 1..8 for icode 7/8; bytes 2..9 for icode 3/4/5. Least-significant byte first.
  - Unused fields: rA = rB = 0xF, valC = 0.
- **Memory error:** `imem_ack` with `imem_err` on any byte sets `stat`=ADR and moves to VALID at once. Remaining bytes are not fetched. valP = pc + bytes fetched so far (including the erroring byte).
- **icode 0:** `stat`=HLT.
- **Leaving FETCH:** move to VALID on the ack of the last byte.
- **VALID:**
  - `instr_valid`=1; all outputs are held stable; `imem_req`=0.
  - On `instr_ready`, the transfer completes: go to HALTED if `stat`≠AOK, else to IDLE.
- **IDLE:**
  - `instr_valid`=0.
  - On `pc_load`, pc ← `pc_in`, idx ← 0, go to FETCH.
- **HALTED:**
  - `instr_valid`=0 and `imem_req`=0. Output fields retain their last values.
  - `pc_load` is ignored; only reset exits this state.
- **Ignored `pc_load`:** `pc_load` in FETCH, VALID or HALTED is ignored. PC update must wait for the transfer before loading.
- **Reset mid-operation:** asynchronous return to the reset state. Partially assembled bytes are discarded.

## Timing
- Entering FETCH at cycle T with ack every cycle:
  - byte k is acked at T+k;
  - `instr_valid` rises at T+n, where n is the length.
- Stalled acks extend FETCH one cycle each; `imem_addr` is held.
- `pc_load` sampled at cycle L in IDLE → `imem_req` high at L+1 with `imem_addr`=`pc_in`.
- `instr_valid` and `instr_ready` both high at cycle V → `instr_valid` low at V+1.
- After a reset release at R, the first request is at R+1 with address 0.
- Outputs are registered; no combinational path from `imem_data` to the decoded fields.

## Test plan
- **irmovq:**
  - Stimulus: pc=0x100, bytes 30 F3 88 77 66 55 44 33 22 11, ack every cycle.
  - Response: `instr_valid` at T+10, icode=3, rA=F, rB=3, valC=0x1122334455667788, valP=0x10A, `stat`=AOK.
- **jXX then load:**
  - Stimulus: bytes 73 00 02 00 00 00 00 00 00 at pc=0; accept; `pc_load` with `pc_in`=0x200.
  - Response: icode=7, ifun=3, valC=0x200, valP=0x9; IDLE; next request addr=0x200.
- **Wrap and stall:**
  - Stimulus: pc=0xFFFF_FFFF_FFFF_FFFF, bytes 60 12, with the ack stalled 3 cycles on byte 1.
  - Response: second address=0; valP=0x1; `instr_valid` 5 cycles after FETCH entry; `stat`=AOK.
- **halt / invalid:**
  - Stimulus: byte 00, or byte D0.
  - Response: `stat`=HLT or INS, valP=pc+1. After accept, state HALTED; a later `pc_load` produces no `imem_req`.
- **Address error:**
  - Stimulus: `imem_err` on byte 2 of an rmmovq at pc=0x40.
  - Response: `stat`=ADR, valP=0x43, no further requests.
- **Reset mid-fetch:**
  - Stimulus: `rst_n` low during byte 4 of an irmovq.
  - Response: `instr_valid`=0, `imem_req`=0 immediately. After release, the fetch restarts at addr 0.
